// File: rtl/proc_scheduler_if.sv
// Handshake and status bundle between the scheduler and its kernel/context-unit partners.
// QW must equal $clog2(QUANTUM+1) of the attached scheduler.
interface proc_scheduler_if #(
    parameter int QW = 7
);
    logic          Instr_Retire;
    logic          Halt;
    logic          Exec_Proc;
    logic [1:0]    Exec_ID;
    logic          Load_Valid;
    logic [1:0]    Load_ID;
    logic          Kill_Valid;
    logic [1:0]    Kill_ID;
    logic          Switch_Ack;
    logic          Switch_Req;
    logic [1:0]    Next_ID;
    logic [1:0]    Proc_ID;
    logic [3:0]    Ready_Mask;
    logic [3:0]    Done_Mask;
    logic [QW-1:0] Quantum_Left;

    modport slave (
        input  Instr_Retire, Halt, Exec_Proc, Exec_ID, Load_Valid, Load_ID,
               Kill_Valid, Kill_ID, Switch_Ack,
        output Switch_Req, Next_ID, Proc_ID, Ready_Mask, Done_Mask, Quantum_Left
    );

    modport master (
        output Instr_Retire, Halt, Exec_Proc, Exec_ID, Load_Valid, Load_ID,
               Kill_Valid, Kill_ID, Switch_Ack,
        input  Switch_Req, Next_ID, Proc_ID, Ready_Mask, Done_Mask, Quantum_Left
    );
endinterface

// File: rtl/proc_scheduler.sv
// Round-robin scheduler: kernel in slot 0, user processes in slots 1..3, quantum preemption,
// every context switch requested from the context unit over a req/ack handshake.
module proc_scheduler #(
    parameter int QUANTUM = 100,
    parameter bit AUTO_RR = 1'b1
) (
    input  logic               Slow_Clock,
    input  logic               Reset,
    proc_scheduler_if.slave    bus
);
    localparam int              QW     = $clog2(QUANTUM + 1);
    localparam logic [QW-1:0]   Q_INIT = QW'(QUANTUM);

    typedef enum logic [1:0] {KERNEL, USER, SW_TO_USER, SW_TO_KERNEL} fsm_e;
    typedef enum logic [1:0] {EMPTY = 2'd0, READY = 2'd1, RUNNING = 2'd2, DONE = 2'd3} slot_e;

    fsm_e          state_q, state_d;
    slot_e         slot_q [1:3];
    slot_e         slot_d [1:3];
    logic [1:0]    proc_id_q, proc_id_d;
    logic [1:0]    next_id_q, next_id_d;
    logic [1:0]    rr_q, rr_d;
    logic          req_q, req_d;
    logic          kill_pend_q, kill_pend_d;
    logic [QW-1:0] qleft_q, qleft_d;
    logic [3:0]    ready_q, ready_d;
    logic [3:0]    done_q, done_d;

    logic          kill_hit;
    logic          rr_hit;
    logic [1:0]    rr_pick;
    logic [1:0]    cand;
    logic          leave;

    function automatic logic [1:0] wrap_next(input logic [1:0] id);
        return (id == 2'd3) ? 2'd1 : id + 2'd1;
    endfunction

    always_comb begin
        // NOTE: every variable gets its default before any branch, so no path can infer a latch.
        state_d     = state_q;
        slot_d      = slot_q;
        proc_id_d   = proc_id_q;
        next_id_d   = next_id_q;
        rr_d        = rr_q;
        req_d       = req_q;
        kill_pend_d = kill_pend_q;
        qleft_d     = qleft_q;
        rr_hit      = 1'b0;
        rr_pick     = 2'd0;
        cand        = rr_q;
        leave       = 1'b0;

        // Round-robin search over the pre-edge slot state, starting at the pointer.
        for (int k = 0; k < 3; k++) begin
            if (!rr_hit && slot_q[cand] == READY) begin
                rr_hit  = 1'b1;
                rr_pick = cand;
            end
            cand = wrap_next(cand);
        end

        kill_hit = bus.Kill_Valid && (bus.Kill_ID != 2'd0);
        if (bus.Load_Valid && bus.Load_ID != 2'd0 &&
            (slot_q[bus.Load_ID] == EMPTY || slot_q[bus.Load_ID] == DONE))
            slot_d[bus.Load_ID] = READY;
        if (kill_hit)
            slot_d[bus.Kill_ID] = EMPTY;

        case (state_q)
            KERNEL: begin
                if (bus.Exec_Proc && bus.Exec_ID != 2'd0 && slot_q[bus.Exec_ID] == READY) begin
                    next_id_d   = bus.Exec_ID;
                    req_d       = 1'b1;
                    state_d     = SW_TO_USER;
                    kill_pend_d = kill_hit && (bus.Kill_ID == bus.Exec_ID);
                end else if (AUTO_RR && rr_hit) begin
                    next_id_d   = rr_pick;
                    req_d       = 1'b1;
                    state_d     = SW_TO_USER;
                    kill_pend_d = kill_hit && (bus.Kill_ID == rr_pick);
                end
            end
            SW_TO_USER: begin
                if (kill_hit && bus.Kill_ID == next_id_q)
                    kill_pend_d = 1'b1;
                if (bus.Switch_Ack) begin
                    proc_id_d = next_id_q;
                    qleft_d   = Q_INIT;
                    rr_d      = wrap_next(next_id_q);
                    req_d     = 1'b0;
                    state_d   = USER;
                    // A target killed while waiting stays EMPTY and is left on the next cycle.
                    if (!kill_pend_d)
                        slot_d[next_id_q] = RUNNING;
                end
            end
            USER: begin
                if (bus.Instr_Retire && qleft_q != '0)
                    qleft_d = qleft_q - QW'(1);
                leave = 1'b1;
                if (kill_pend_q || (kill_hit && bus.Kill_ID == proc_id_q))
                    slot_d[proc_id_q] = EMPTY;
                else if (bus.Halt && bus.Instr_Retire)
                    slot_d[proc_id_q] = DONE;
                else if (bus.Instr_Retire && qleft_q == QW'(1))
                    slot_d[proc_id_q] = READY;
                else
                    leave = 1'b0;
                if (leave) begin
                    next_id_d   = 2'd0;
                    req_d       = 1'b1;
                    kill_pend_d = 1'b0;
                    state_d     = SW_TO_KERNEL;
                end
            end
            SW_TO_KERNEL: begin
                if (bus.Switch_Ack) begin
                    proc_id_d = 2'd0;
                    req_d     = 1'b0;
                    state_d   = KERNEL;
                end
            end
            default: state_d = KERNEL;
        endcase

        ready_d = 4'b0000;
        done_d  = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            ready_d[i] = (slot_d[i] == READY);
            done_d[i]  = (slot_d[i] == DONE);
        end
    end

    always_ff @(posedge Slow_Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state_q     <= KERNEL;
            proc_id_q   <= 2'd0;
            next_id_q   <= 2'd0;
            rr_q        <= 2'd1;
            req_q       <= 1'b0;
            kill_pend_q <= 1'b0;
            qleft_q     <= Q_INIT;
            ready_q     <= 4'b0000;
            done_q      <= 4'b0000;
            for (int i = 1; i <= 3; i++)
                slot_q[i] <= EMPTY;
        end else begin
            state_q     <= state_d;
            proc_id_q   <= proc_id_d;
            next_id_q   <= next_id_d;
            rr_q        <= rr_d;
            req_q       <= req_d;
            kill_pend_q <= kill_pend_d;
            qleft_q     <= qleft_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            for (int i = 1; i <= 3; i++)
                slot_q[i] <= slot_d[i];
        end
    end

    assign bus.Switch_Req   = req_q;
    assign bus.Next_ID      = next_id_q;
    assign bus.Proc_ID      = proc_id_q;
    assign bus.Ready_Mask   = ready_q;
    assign bus.Done_Mask    = done_q;
    assign bus.Quantum_Left = qleft_q;
endmodule

// File: tb/tb_proc_scheduler.sv
// Directed bench for proc_scheduler: an auto round-robin instance (QUANTUM=5) and an explicit-exec
// instance (QUANTUM=4); expected dispatch targets are queued when issued and popped on Switch_Req.
module tb_proc_scheduler;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    proc_scheduler_if #(.QW(3)) ifa ();
    proc_scheduler_if #(.QW(3)) ifb ();

    proc_scheduler #(.QUANTUM(5), .AUTO_RR(1'b1)) u_a (
        .Slow_Clock (clk),
        .Reset      (rst_a),
        .bus        (ifa)
    );

    proc_scheduler #(.QUANTUM(4), .AUTO_RR(1'b0)) u_b (
        .Slow_Clock (clk),
        .Reset      (rst_b),
        .bus        (ifb)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a request on B, then compare Next_ID against the scoreboard head.
    task automatic wait_req_b(input string tag);
        logic [1:0] want;
        for (int i = 0; i < 20 && !ifb.Switch_Req; i++) step();
        chk({tag, "_req"}, ifb.Switch_Req, 1);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd0;
        chk({tag, "_next"}, ifb.Next_ID, want);
    endtask

    task automatic exec_b(input logic [1:0] id);
        exp_q.push_back(id);
        ifb.Exec_Proc = 1'b1;
        ifb.Exec_ID   = id;
        step();
        ifb.Exec_Proc = 1'b0;
        ifb.Exec_ID   = 2'd0;
    endtask

    task automatic load_b(input logic [1:0] id);
        ifb.Load_Valid = 1'b1;
        ifb.Load_ID    = id;
        step();
        ifb.Load_Valid = 1'b0;
    endtask

    task automatic ack_b();
        ifb.Switch_Ack = 1'b1;
        step();
        ifb.Switch_Ack = 1'b0;
    endtask

    initial begin
        logic [1:0] want;
        logic [1:0] order[4];

        {ifa.Instr_Retire, ifa.Halt, ifa.Exec_Proc, ifa.Load_Valid, ifa.Kill_Valid, ifa.Switch_Ack} = '0;
        {ifa.Exec_ID, ifa.Load_ID, ifa.Kill_ID} = '0;
        {ifb.Instr_Retire, ifb.Halt, ifb.Exec_Proc, ifb.Load_Valid, ifb.Kill_Valid, ifb.Switch_Ack} = '0;
        {ifb.Exec_ID, ifb.Load_ID, ifb.Kill_ID} = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(2);
        rst_a = 1'b0;
        rst_b = 1'b0;

        chk("a_rst_proc", ifa.Proc_ID, 0);
        chk("a_rst_req", ifa.Switch_Req, 0);
        chk("a_rst_ready", ifa.Ready_Mask, 4'b0000);
        chk("a_rst_done", ifa.Done_Mask, 4'b0000);
        chk("a_rst_qleft", ifa.Quantum_Left, 5);
        chk("b_rst_qleft", ifb.Quantum_Left, 4);

        // Auto round-robin: order 1,2,3,1, each leaving after exactly 5 retires.
        order = '{2'd1, 2'd2, 2'd3, 2'd1};
        foreach (order[i]) exp_q.push_back(order[i]);
        ifa.Load_Valid = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            ifa.Load_ID = 2'(s);
            step();
        end
        ifa.Load_Valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 20 && !ifa.Switch_Req; i++) step();
            chk("rr_req", ifa.Switch_Req, 1);
            want = exp_q.pop_front();
            chk("rr_next", ifa.Next_ID, want);
            ifa.Switch_Ack = 1'b1;
            step();
            ifa.Switch_Ack = 1'b0;
            chk("rr_proc", ifa.Proc_ID, want);
            chk("rr_req_drop", ifa.Switch_Req, 0);
            chk("rr_qleft", ifa.Quantum_Left, 5);
            chk("rr_ready", ifa.Ready_Mask, 4'b1110 & ~(4'b0001 << want));
            ifa.Instr_Retire = 1'b1;
            step(4);
            chk("rr_no_early_req", ifa.Switch_Req, 0);
            chk("rr_qleft1", ifa.Quantum_Left, 1);
            step();
            ifa.Instr_Retire = 1'b0;
            chk("rr_expire_req", ifa.Switch_Req, 1);
            chk("rr_expire_next", ifa.Next_ID, 0);
            chk("rr_expire_qleft", ifa.Quantum_Left, 0);
            ifa.Switch_Ack = 1'b1;
            step();
            ifa.Switch_Ack = 1'b0;
            chk("rr_kernel_proc", ifa.Proc_ID, 0);
            chk("rr_kernel_req", ifa.Switch_Req, 0);
        end

        // Exec to an EMPTY slot is ignored; after loading, the held request stays stable.
        ifb.Exec_Proc = 1'b1;
        ifb.Exec_ID   = 2'd2;
        step();
        ifb.Exec_Proc = 1'b0;
        step();
        chk("ex_empty_req", ifb.Switch_Req, 0);
        load_b(2'd2);
        chk("ex_ready2", ifb.Ready_Mask, 4'b0100);
        exec_b(2'd2);
        wait_req_b("ex2");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ex_hold_req", ifb.Switch_Req, 1);
            chk("ex_hold_next", ifb.Next_ID, 2);
        end
        ack_b();
        chk("ex_proc2", ifb.Proc_ID, 2);
        ifb.Instr_Retire = 1'b1;
        step(3);
        chk("ex_q_not_yet", ifb.Switch_Req, 0);
        step();
        ifb.Instr_Retire = 1'b0;
        chk("ex_q_req", ifb.Switch_Req, 1);
        chk("ex_q_next", ifb.Next_ID, 0);
        ack_b();
        chk("ex_back_proc", ifb.Proc_ID, 0);
        step(2);
        chk("ex_no_auto", ifb.Switch_Req, 0);

        // Halt on the 2nd retire marks slot 1 DONE; it is not dispatched again until reloaded.
        load_b(2'd1);
        exec_b(2'd1);
        wait_req_b("h1");
        ack_b();
        chk("h_proc1", ifb.Proc_ID, 1);
        ifb.Instr_Retire = 1'b1;
        step();
        chk("h_first_no_req", ifb.Switch_Req, 0);
        ifb.Halt = 1'b1;
        step();
        ifb.Instr_Retire = 1'b0;
        ifb.Halt = 1'b0;
        chk("h_req", ifb.Switch_Req, 1);
        chk("h_next", ifb.Next_ID, 0);
        chk("h_done", ifb.Done_Mask, 4'b0010);
        chk("h_ready", ifb.Ready_Mask, 4'b0100);
        ack_b();
        ifb.Exec_Proc = 1'b1;
        ifb.Exec_ID   = 2'd1;
        step();
        ifb.Exec_Proc = 1'b0;
        step();
        chk("h_no_redispatch", ifb.Switch_Req, 0);
        load_b(2'd1);
        chk("h_reload_ready", ifb.Ready_Mask, 4'b0110);
        chk("h_reload_done", ifb.Done_Mask, 4'b0000);

        // Kill and Halt together on the running slot: EMPTY wins over DONE.
        load_b(2'd3);
        exec_b(2'd3);
        wait_req_b("k3");
        ack_b();
        chk("k_proc3", ifb.Proc_ID, 3);
        ifb.Kill_Valid   = 1'b1;
        ifb.Kill_ID      = 2'd3;
        ifb.Instr_Retire = 1'b1;
        ifb.Halt         = 1'b1;
        step();
        {ifb.Kill_Valid, ifb.Instr_Retire, ifb.Halt} = '0;
        chk("k_req", ifb.Switch_Req, 1);
        chk("k_next", ifb.Next_ID, 0);
        chk("k_done", ifb.Done_Mask, 4'b0000);
        chk("k_ready", ifb.Ready_Mask, 4'b0110);
        ack_b();

        // Load and Kill of the same slot in one cycle: Kill wins. Exec of slot 0 is ignored.
        ifb.Kill_Valid = 1'b1;
        ifb.Kill_ID    = 2'd1;
        step();
        chk("lk_kill1", ifb.Ready_Mask, 4'b0100);
        ifb.Load_Valid = 1'b1;
        ifb.Load_ID    = 2'd1;
        step();
        ifb.Load_Valid = 1'b0;
        ifb.Kill_Valid = 1'b0;
        chk("lk_same_cycle", ifb.Ready_Mask, 4'b0100);
        exec_b(2'd0);
        void'(exp_q.pop_back());
        step();
        chk("exec0_no_req", ifb.Switch_Req, 0);

        // Reset while a request awaits its ack; a late ack afterwards is ignored.
        exec_b(2'd2);
        wait_req_b("r2");
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        chk("r_req", ifb.Switch_Req, 0);
        chk("r_proc", ifb.Proc_ID, 0);
        chk("r_next", ifb.Next_ID, 0);
        chk("r_ready", ifb.Ready_Mask, 4'b0000);
        chk("r_done", ifb.Done_Mask, 4'b0000);
        chk("r_qleft", ifb.Quantum_Left, 4);
        ack_b();
        chk("r_late_ack_proc", ifb.Proc_ID, 0);
        chk("r_late_ack_req", ifb.Switch_Req, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
